// File: rtl/dsp_simd_pkg.sv
// Shared types and constants for the SIMD add/sub/accumulate pipeline.
// Lanes are carved out of a 48-bit DSP datapath.
package dsp_simd_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    localparam int DSP_W = 48;

    // Bits of the 48-bit datapath available to each lane.
    function automatic int lane_slot(input int lanes);
        return DSP_W / lanes;
    endfunction

endpackage

// File: rtl/dsp_simd_lane.sv
// One SIMD lane: stage-1 arithmetic and the lane's private accumulator.
// Arithmetic is modulo 2^width, so there is no carry into or out of the lane.
module dsp_simd_lane
    import dsp_simd_pkg::*;
#(
    parameter int width = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             accept,
    input  logic [1:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] r
);

    logic [width-1:0] acc;

    always_comb begin
        r = a;
        case (op_t'(op))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_ACC:  r = acc + a;
            default: r = a;
        endcase
    end

    // accept is already qualified by in_ready, so a stalled or refused
    // transaction can never touch the accumulator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (accept && (op_t'(op) == OP_ACC || op_t'(op) == OP_LOAD)) begin
            acc <= r;
        end
    end

endmodule

// File: rtl/dsp_simd_addsub_pipe.sv
// Pipelined SIMD add/sub/accumulate unit on a valid/ready stream.
// Stage 1 holds the lane results; later stages are pure delay, the last is y.
module dsp_simd_addsub_pipe
    import dsp_simd_pkg::*;
#(
    parameter int width   = 24,
    parameter int LANES   = 2,
    parameter int LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [LANES*width-1:0] a,
    input  logic [LANES*width-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*width-1:0] y
);

    localparam bit LANES_OK = (LANES == 1) || (LANES == 2) || (LANES == 4);
    localparam bit WIDTH_OK = LANES_OK ? (width >= 1 && width <= lane_slot(LANES)) : 1'b0;
    localparam bit LAT_OK   = (LATENCY >= 1) && (LATENCY <= 3);

    generate
        if (!(LANES_OK && WIDTH_OK && LAT_OK)) begin : g_bad_cfg
            $error("dsp_simd_addsub_pipe: illegal width=%0d LANES=%0d LATENCY=%0d",
                   width, LANES, LATENCY);
        end
    endgenerate

    logic                                 stall;
    logic                                 accept;
    logic [LANES*width-1:0]               r_all;
    logic [LATENCY:1]                     vld_pipe;
    logic [LATENCY:1][LANES*width-1:0]    data_pipe;

    // The whole pipe moves as one; when out_valid is low nothing can stall.
    assign stall     = vld_pipe[LATENCY] & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_pipe[LATENCY];
    assign y         = data_pipe[LATENCY];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dsp_simd_lane #(.width(width)) u_lane (
            .clock  (clock),
            .reset  (reset),
            .accept (accept),
            .op     (op),
            .a      (a[i*width +: width]),
            .b      (b[i*width +: width]),
            .r      (r_all[i*width +: width])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[1]  <= accept;
            data_pipe[1] <= r_all;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_dsp_simd_addsub_pipe.sv
// Directed bench: a 2x24 LATENCY=3 instance for stream/stall/reset scenarios
// and a 4x12 LATENCY=1 instance for narrow-lane carry isolation.
module tb_dsp_simd_addsub_pipe;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_op;
    logic [47:0] a_a, a_b, a_y;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_op;
    logic [47:0] b_a, b_b, b_y;

    dsp_simd_addsub_pipe #(.width(24), .LANES(2), .LATENCY(3)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .a(a_a), .b(a_b), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .y(a_y)
    );

    dsp_simd_addsub_pipe #(.width(12), .LANES(4), .LATENCY(1)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .a(b_a), .b(b_b), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .y(b_y)
    );

    // Every transfer out of dut_a, in order.
    logic [47:0] qa[$];
    always @(negedge clock) begin
        if (!reset && a_out_valid && a_out_ready) qa.push_back(a_y);
    end

    logic [1:0]  s_op[8];
    logic [47:0] s_a[8];
    logic [47:0] s_b[8];

    // Drives s_* back-to-back into dut_a, holding out_ready low for loop
    // cycles stall_lo..stall_hi; counts handshake/stability violations.
    task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                              output int viol);
        int          idx = 0;
        int          k = 0;
        bit          took;
        bit          stalled_prev = 0;
        logic [47:0] stall_y = '0;
        viol = 0;
        while ((idx < n || qa.size() < n) && k < 100) begin
            a_out_ready = !(k >= stall_lo && k <= stall_hi);
            if (idx < n) begin
                a_in_valid = 1'b1; a_op = s_op[idx]; a_a = s_a[idx]; a_b = s_b[idx];
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clock);
            if (a_out_valid && !a_out_ready && a_in_ready) viol++;
            if (stalled_prev && a_y !== stall_y) viol++;
            stalled_prev = a_out_valid && !a_out_ready;
            stall_y = a_y;
            took = a_in_valid && a_in_ready;
            @(posedge clock); #1;
            if (took) idx++;
            k++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_in_valid = 0; a_op = ADD; a_a = '0; a_b = '0; a_out_ready = 1'b1;
        b_in_valid = 0; b_op = ADD; b_a = '0; b_b = '0; b_out_ready = 1'b1;
        #12;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %b want 0", a_out_valid); end
        checks++; if (a_y !== 48'h0) begin errors++; $display("FAIL reset_a_y got %h want 0", a_y); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %b want 0", b_out_valid); end
        checks++; if (b_y !== 48'h0) begin errors++; $display("FAIL reset_b_y got %h want 0", b_y); end
        @(negedge clock); reset = 1'b0; #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    endtask

    task automatic test_carry_isolation;
        int n = 0;
        @(posedge clock); #1;
        a_in_valid = 1'b1; a_op = ADD; a_a = {24'h000000, 24'h7FFFFF}; a_b = {24'h000000, 24'h000001};
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        while (!a_out_valid && n < 10) begin @(posedge clock); #1; n++; end
        checks++; if (n !== 2) begin errors++; $display("FAIL add_latency got %0d extra edges want 2", n); end
        checks++; if (a_y !== {24'h000000, 24'h800000}) begin errors++; $display("FAIL add_carry_iso got %h want 000000800000", a_y); end
        @(posedge clock); #1;
    endtask

    task automatic test_sub_wrap;
        int viol;
        qa.delete();
        s_op[0] = SUB; s_a[0] = {24'd5, 24'd0};        s_b[0] = {24'd7, 24'd1};
        s_op[1] = ADD; s_a[1] = {24'd0, 24'hFFFFFF};   s_b[1] = {24'd0, 24'd1};
        run_stream(2, 100, 100, viol);
        checks++; if (qa.size() !== 2) begin errors++; $display("FAIL sub_count got %0d want 2", qa.size()); end
        else begin
            checks++; if (qa[0] !== {24'hFFFFFE, 24'hFFFFFF}) begin errors++; $display("FAIL sub_wrap got %h want FFFFFEFFFFFF", qa[0]); end
            checks++; if (qa[1] !== 48'h0) begin errors++; $display("FAIL add_wrap got %h want 0", qa[1]); end
        end
    endtask

    task automatic test_load_acc;
        int          viol;
        logic [47:0] exp_y[4];
        qa.delete();
        s_op[0] = LOAD; s_a[0] = {24'h10, 24'h20}; s_b[0] = {24'h55, 24'h66};
        for (int i = 1; i < 4; i++) begin
            s_op[i] = ACC; s_a[i] = {24'h1, 24'h2}; s_b[i] = {24'h77, 24'h99};
        end
        exp_y[0] = {24'h10, 24'h20}; exp_y[1] = {24'h11, 24'h22};
        exp_y[2] = {24'h12, 24'h24}; exp_y[3] = {24'h13, 24'h26};
        run_stream(4, 100, 100, viol);
        checks++; if (qa.size() !== 4) begin errors++; $display("FAIL acc_count got %0d want 4", qa.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (qa[i] !== exp_y[i]) begin errors++; $display("FAIL acc_chain[%0d] got %h want %h", i, qa[i], exp_y[i]); end
        end
    endtask

    task automatic test_back_to_back_stall;
        int viol;
        qa.delete();
        for (int i = 0; i < 6; i++) begin
            s_op[i] = ADD; s_a[i] = {24'(i), 24'(16 * i)}; s_b[i] = {24'd1, 24'd2};
        end
        run_stream(6, 4, 6, viol);
        checks++; if (viol !== 0) begin errors++; $display("FAIL stall_handshake got %0d violations want 0", viol); end
        checks++; if (qa.size() !== 6) begin errors++; $display("FAIL stall_count got %0d want 6", qa.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++;
            if (qa[i] !== {24'(i + 1), 24'(16 * i + 2)}) begin
                errors++; $display("FAIL stall_order[%0d] got %h want %h", i, qa[i], {24'(i + 1), 24'(16 * i + 2)});
            end
        end
    endtask

    task automatic test_reset_flush;
        int viol;
        @(posedge clock); #1;
        a_in_valid = 1'b1; a_op = ACC; a_a = {24'd5, 24'd5}; a_b = '0;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1; #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", a_out_valid); end
        checks++; if (a_y !== 48'h0) begin errors++; $display("FAIL flush_y got %h want 0", a_y); end
        #2 reset = 1'b0;
        qa.delete();
        repeat (5) @(posedge clock);
        #1;
        checks++; if (qa.size() !== 0) begin errors++; $display("FAIL flush_discard got %0d results want 0", qa.size()); end
        qa.delete();
        s_op[0] = ACC; s_a[0] = {24'd3, 24'd3}; s_b[0] = {24'd9, 24'd9};
        run_stream(1, 100, 100, viol);
        checks++;
        if (qa.size() !== 1 || qa[0] !== {24'd3, 24'd3}) begin
            errors++; $display("FAIL flush_acc_cleared got %h (n=%0d) want 000003000003", qa.size() ? qa[0] : 48'hx, qa.size());
        end
    endtask

    task automatic test_four_lane;
        @(posedge clock); #1;
        b_in_valid = 1'b1; b_op = ADD;
        b_a = {12'hFFF, 12'h000, 12'h800, 12'h001}; b_b = {12'h001, 12'h000, 12'h800, 12'h001};
        @(posedge clock); #1;
        b_op = SUB;
        b_a = {12'h000, 12'h005, 12'h800, 12'h000}; b_b = {12'h001, 12'h003, 12'h7FF, 12'h001};
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL lane4_add_valid got %b want 1", b_out_valid); end
        checks++; if (b_y !== {12'h000, 12'h000, 12'h000, 12'h002}) begin errors++; $display("FAIL lane4_add got %h want 000000000002", b_y); end
        @(posedge clock); #1;
        b_in_valid = 1'b0;
        checks++; if (b_y !== {12'hFFF, 12'h002, 12'h001, 12'hFFF}) begin errors++; $display("FAIL lane4_sub got %h want FFF002001FFF", b_y); end
        @(posedge clock); #1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL lane4_drain got %b want 0", b_out_valid); end
    endtask

    initial begin
        test_reset();
        test_carry_isolation();
        test_sub_wrap();
        test_load_acc();
        test_back_to_back_stall();
        test_reset_flush();
        test_four_lane();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
